// File: rtl/fht_wb.sv
// fht_wb: write-back stage for the FHT butterfly. Buffers (y0, y1) result
// pairs with their RAM addresses in a small pair FIFO. Each pair is then
// written to the single-port working RAM as two single-word writes, y0 first.
// Latency: a pair pushed into an empty, idle stage shows y0 on the write port
// one cycle after acceptance and y1 one cycle later. Sustained rate is one
// pair per two cycles.
// Backpressure: oREADY drops while the FIFO is full. iSTALL freezes the write
// port, because the reader owns the RAM in that cycle.
// Ports: iCLK/iRESET clock and sync active-high reset; iVALID/oREADY/iY_*/
// iADDR_* form the pair input; iSTALL, oWR_EN, oWR_ADDR and oWR_DATA form the
// RAM write port; oBUSY means there is work pending; oOVF_CNT is present only
// when FHT_WB_OVF_EN is defined.
// Optional feature macro: FHT_WB_OVF_EN. It enables the saturating overflow
// counter.
module fht_wb #(
  parameter int D_BIT = 18,
  parameter int A_BIT = 10,
  parameter int DEPTH = 4
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iVALID,
  input  logic signed [D_BIT-1:0] iY_0,
  input  logic signed [D_BIT-1:0] iY_1,
  input  logic [A_BIT-1:0]        iADDR_0,
  input  logic [A_BIT-1:0]        iADDR_1,
  output logic                    oREADY,
  input  logic                    iSTALL,
  output logic                    oWR_EN,
  output logic [A_BIT-1:0]        oWR_ADDR,
  output logic [D_BIT-1:0]        oWR_DATA,
  output logic                    oBUSY
`ifdef FHT_WB_OVF_EN
  ,
  output logic [15:0]             oOVF_CNT
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [A_BIT-1:0] addr0;
    logic [D_BIT-1:0] y0;
    logic [A_BIT-1:0] addr1;
    logic [D_BIT-1:0] y1;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q;
  logic             wr_en_q;
  logic [A_BIT-1:0] wr_addr_q;
  logic [D_BIT-1:0] wr_data_q;

  logic   full, push, pop;
  entry_t in_entry, head, next_head;

  assign full   = (count_q == CW'(DEPTH));
  assign oREADY = !full && !iRESET;
  assign push   = iVALID && oREADY;
  assign pop    = (state_q == WR1) && !iSTALL;

  assign count_d = count_q + CW'(push) - CW'(pop);
  assign rd_nxt  = rd_ptr_q + PW'(1);

  always_comb begin
    in_entry       = '0;
    in_entry.addr0 = iADDR_0;
    in_entry.y0    = iY_0;
    in_entry.addr1 = iADDR_1;
    in_entry.y1    = iY_1;
  end

  assign head = mem_q[rd_ptr_q];

  // Suppose only the head is buffered when it is popped. Any follow-on pair
  // arrives in this same edge, and it is not in the array yet, so the input is
  // forwarded directly. This keeps WR1 -> WR0 back-to-back, with no IDLE bubble.
  assign next_head = (count_q > CW'(1)) ? mem_q[rd_nxt] : in_entry;

  // The pair storage has no reset. The count and pointers decide which
  // entries are valid.
  always_ff @(posedge iCLK) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_nxt;
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q   <= WR0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= head.addr0;
            wr_data_q <= head.y0;
          end
        end
        WR0: begin
          if (!iSTALL) begin
            state_q   <= WR1;
            wr_addr_q <= head.addr1;
            wr_data_q <= head.y1;
          end
        end
        WR1: begin
          if (!iSTALL) begin
            if (count_d != '0) begin
              state_q   <= WR0;
              wr_addr_q <= next_head.addr0;
              wr_data_q <= next_head.y0;
            end else begin
              // Address and data keep their last values while idle.
              state_q <= IDLE;
              wr_en_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign oWR_EN   = wr_en_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oBUSY    = (count_q != '0) || (state_q != IDLE);

`ifdef FHT_WB_OVF_EN
  // A word counts as overflowed when its two MSBs disagree, which means it
  // has left the representable range. Each word of an accepted pair is
  // checked on its own.
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic [1:0]  ovf_inc;
  logic [16:0] ovf_sum;

  assign ovf_inc = push ? (2'(iY_0[D_BIT-1] ^ iY_0[D_BIT-2]) +
                           2'(iY_1[D_BIT-1] ^ iY_1[D_BIT-2])) : 2'd0;
  assign ovf_sum   = {1'b0, ovf_cnt_q} + 17'(ovf_inc);
  assign ovf_cnt_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];

  always_ff @(posedge iCLK) begin
    if (iRESET) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign oOVF_CNT = ovf_cnt_q;
`endif

endmodule
